nt3137_activity_monitor: RTL and testbench

Sequential observer for the I3137 node of a benchmark subcircuit. It sits directly downstream of that subcircuit and consumes the single-bit I3137 output. Over fixed-length sampling windows it counts toggles, high cycles and occurrences of a target bit sequence, and flags windows with rare activity. Per-window results go out through a valid/ready handshake to the trojan-detection collection logic.

---
 rtl/nt3137_activity_monitor.sv | 175 +++++++++++++++++
 tb/tb_nt3137_activity_monitor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nt3137_activity_monitor.sv
// Windowed activity observer for node I3137: counts toggles, ones and target
// sequence hits per window and hands each result off over valid/ready.
module nt3137_activity_monitor #(
  parameter int                 WIN_LEN  = 256,
  parameter int                 CNT_W    = 9,
  parameter int                 SEQ_LEN  = 4,
  parameter logic [SEQ_LEN-1:0] SEQ_PAT  = 4'b1011,
  parameter int                 RARE_THR = 2
) (
  input  logic             I1294_clk,
  input  logic             I1301_rst,
  input  logic             I3137,
  input  logic             mon_en,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [CNT_W-1:0] res_toggles,
  output logic [CNT_W-1:0] res_ones,
  output logic [CNT_W-1:0] res_seq_hits,
  output logic             res_rare,
  output logic             overrun
);

  typedef enum logic [0:0] {IDLE = 1'b0, SAMPLE = 1'b1} state_t;

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   idx_r;
  logic [CNT_W-1:0]   ones_r;
  logic [CNT_W-1:0]   tog_r;
  logic [CNT_W-1:0]   hits_r;
  logic [SEQ_LEN-1:0] shift_r;
  logic               prev_r;
  logic               prev_valid_r;
  logic [CNT_W-1:0]   fin_ones_r;
  logic [CNT_W-1:0]   fin_tog_r;
  logic [CNT_W-1:0]   fin_hits_r;
  logic               fin_valid_r;

  logic               capture_s;
  logic               clear_s;
  logic               finish_s;
  logic [CNT_W-1:0]   sample_idx_s;
  logic               last_s;
  logic [SEQ_LEN-1:0] shift_nx_s;
  logic               toggle_s;
  logic               hit_s;
  logic [CNT_W-1:0]   ones_nx_s;
  logic [CNT_W-1:0]   tog_nx_s;
  logic [CNT_W-1:0]   hits_nx_s;

  // Per-sample arithmetic: the incoming bit becomes sample idx_r+1.
  always_comb begin
    sample_idx_s = idx_r + CNT_W'(1);
    last_s       = (idx_r == CNT_W'(WIN_LEN - 1));
    shift_nx_s   = SEQ_LEN'({shift_r, I3137});
    toggle_s     = prev_valid_r && (I3137 != prev_r);
    hit_s        = (sample_idx_s >= CNT_W'(SEQ_LEN)) && (shift_nx_s == SEQ_PAT);
    ones_nx_s    = ones_r + CNT_W'(I3137);
    tog_nx_s     = tog_r + CNT_W'(toggle_s);
    hits_nx_s    = hits_r + CNT_W'(hit_s);
  end

  // State register.
  always_ff @(posedge I1294_clk) begin
    if (I1301_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and datapath controls; the last sample of a window is never gated by mon_en.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    clear_s   = 1'b0;
    finish_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (mon_en) begin
          state_s = SAMPLE;
          clear_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SAMPLE: begin
        if (last_s) begin
          finish_s = 1'b1;
          clear_s  = 1'b1;
          state_s  = mon_en ? SAMPLE : IDLE;
        end else if (mon_en) begin
          capture_s = 1'b1;
          state_s   = SAMPLE;
        end else begin
          clear_s = 1'b1;
          state_s = IDLE;
        end
      end
      default: begin
        clear_s = 1'b1;
        state_s = IDLE;
      end
    endcase
  end

  // Working counters for the window in progress.
  always_ff @(posedge I1294_clk) begin
    if (I1301_rst) begin
      idx_r        <= '0;
      ones_r       <= '0;
      tog_r        <= '0;
      hits_r       <= '0;
      shift_r      <= '0;
      prev_r       <= 1'b0;
      prev_valid_r <= 1'b0;
    end else if (capture_s) begin
      idx_r        <= sample_idx_s;
      ones_r       <= ones_nx_s;
      tog_r        <= tog_nx_s;
      hits_r       <= hits_nx_s;
      shift_r      <= shift_nx_s;
      prev_r       <= I3137;
      prev_valid_r <= 1'b1;
    end else if (clear_s) begin
      idx_r        <= '0;
      ones_r       <= '0;
      tog_r        <= '0;
      hits_r       <= '0;
      shift_r      <= '0;
      prev_r       <= 1'b0;
      prev_valid_r <= 1'b0;
    end
  end

  // Completed-window stage, lets the next window start without a gap.
  always_ff @(posedge I1294_clk) begin
    if (I1301_rst) begin
      fin_ones_r  <= '0;
      fin_tog_r   <= '0;
      fin_hits_r  <= '0;
      fin_valid_r <= 1'b0;
    end else if (finish_s) begin
      fin_ones_r  <= ones_nx_s;
      fin_tog_r   <= tog_nx_s;
      fin_hits_r  <= hits_nx_s;
      fin_valid_r <= 1'b1;
    end else begin
      fin_valid_r <= 1'b0;
    end
  end

  // Result slot: load when free or being consumed, otherwise drop and flag overrun.
  always_ff @(posedge I1294_clk) begin
    if (I1301_rst) begin
      res_valid    <= 1'b0;
      res_toggles  <= '0;
      res_ones     <= '0;
      res_seq_hits <= '0;
      res_rare     <= 1'b0;
      overrun      <= 1'b0;
    end else if (fin_valid_r && (!res_valid || res_ready)) begin
      res_valid    <= 1'b1;
      res_toggles  <= fin_tog_r;
      res_ones     <= fin_ones_r;
      res_seq_hits <= fin_hits_r;
      res_rare     <= (int'(fin_tog_r) < RARE_THR);
    end else if (fin_valid_r) begin
      overrun      <= 1'b1;
    end else if (res_valid && res_ready) begin
      res_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nt3137_activity_monitor.sv
// Scoreboard bench for nt3137_activity_monitor: a window-level reference model
// predicts results, a negedge monitor compares each handshake and the flags.
module tb_nt3137_activity_monitor;

  localparam int               WIN_LEN  = 8;
  localparam int               CNT_W    = 4;
  localparam int               SEQ_LEN  = 4;
  localparam logic [3:0]       SEQ_PAT  = 4'b1011;
  localparam int               RARE_THR = 2;

  typedef struct {
    int tog;
    int ones;
    int hits;
    int rare;
  } res_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             din = 1'b0;
  logic             mon_en = 1'b0;
  logic             res_ready = 1'b0;
  logic             res_valid;
  logic [CNT_W-1:0] res_toggles;
  logic [CNT_W-1:0] res_ones;
  logic [CNT_W-1:0] res_seq_hits;
  logic             res_rare;
  logic             overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  nt3137_activity_monitor #(
    .WIN_LEN(WIN_LEN), .CNT_W(CNT_W), .SEQ_LEN(SEQ_LEN),
    .SEQ_PAT(SEQ_PAT), .RARE_THR(RARE_THR)
  ) dut (
    .I1294_clk(clk), .I1301_rst(rst), .I3137(din), .mon_en(mon_en),
    .res_ready(res_ready), .res_valid(res_valid), .res_toggles(res_toggles),
    .res_ones(res_ones), .res_seq_hits(res_seq_hits), .res_rare(res_rare),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Window scoring straight from the counting rules.
  function automatic res_t score(input bit w[$]);
    res_t r;
    logic [3:0] pat;
    bit m;
    pat = SEQ_PAT;
    r.tog = 0; r.ones = 0; r.hits = 0;
    for (int i = 0; i < w.size(); i++) begin
      r.ones += int'(w[i]);
      if (i > 0 && w[i] != w[i-1]) r.tog++;
    end
    for (int i = SEQ_LEN - 1; i < w.size(); i++) begin
      m = 1'b1;
      for (int k = 0; k < SEQ_LEN; k++)
        if (w[i-SEQ_LEN+1+k] != pat[SEQ_LEN-1-k]) m = 1'b0;
      if (m) r.hits++;
    end
    r.rare = (r.tog < RARE_THR) ? 1 : 0;
    return r;
  endfunction

  // Reference model state
  bit   m_active = 1'b0;
  bit   m_valid  = 1'b0;
  bit   m_over   = 1'b0;
  bit   m_staged = 1'b0;
  res_t m_stage_res;
  bit   m_win[$];
  res_t sb[$];

  // Model advances on each rising edge using the inputs applied before it.
  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_valid = 1'b0; m_over = 1'b0; m_staged = 1'b0;
      m_win.delete(); sb.delete();
    end else begin
      if (m_staged) begin
        if (!m_valid || res_ready) begin
          m_valid = 1'b1;
          sb.push_back(m_stage_res);
        end else begin
          m_over = 1'b1;
        end
        m_staged = 1'b0;
      end else if (m_valid && res_ready) begin
        m_valid = 1'b0;
      end
      if (!m_active) begin
        if (mon_en) begin
          m_active = 1'b1;
          m_win.delete();
        end
      end else if (mon_en || m_win.size() == WIN_LEN - 1) begin
        m_win.push_back(din);
        if (m_win.size() == WIN_LEN) begin
          m_stage_res = score(m_win);
          m_staged = 1'b1;
          m_win.delete();
          m_active = mon_en;
        end
      end else begin
        m_active = 1'b0;
        m_win.delete();
      end
    end
  end

  // Monitor: flags every cycle, result data on each accepted handshake.
  always @(negedge clk) begin
    res_t e;
    chk("res_valid", int'(res_valid), int'(m_valid));
    chk("overrun", int'(overrun), int'(m_over));
    if (res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("res_toggles", int'(res_toggles), e.tog);
        chk("res_ones", int'(res_ones), e.ones);
        chk("res_seq_hits", int'(res_seq_hits), e.hits);
        chk("res_rare", int'(res_rare), e.rare);
      end
    end
  end

  task automatic step(input bit r, input bit en, input bit d, input bit rdy);
    @(posedge clk);
    #1;
    rst = r; mon_en = en; din = d; res_ready = rdy;
  endtask

  task automatic run_window(input logic [7:0] pat, input bit rdy);
    step(1'b0, 1'b1, 1'b0, rdy);
    for (int i = 7; i >= 0; i--) step(1'b0, i != 0, pat[i], rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rdy);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, int'(res_valid), 0);
    chk({tag, "_toggles"}, int'(res_toggles), 0);
    chk({tag, "_ones"}, int'(res_ones), 0);
    chk({tag, "_hits"}, int'(res_seq_hits), 0);
    chk({tag, "_rare"}, int'(res_rare), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_all_zero("reset");

    run_window(8'b0000_0000, 1'b1);
    idle(4, 1'b1);
    run_window(8'b1010_1010, 1'b1);
    idle(4, 1'b1);
    run_window(8'b1011_0110, 1'b1);
    idle(4, 1'b1);

    // Pending result, then reset in the middle of the next window at i=5
    run_window(8'b1100_1010, 1'b0);
    idle(2, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2 * WIN_LEN + 2, 1'b1);
    @(negedge clk);
    chk_all_zero("midreset");

    // Three back-to-back windows with the consumer stalled
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 3 * WIN_LEN; k++)
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Abort at i=3, then a clean restart
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2 * WIN_LEN, 1'b1);
    run_window(8'b0110_1101, 1'b1);
    idle(4, 1'b1);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 599) == 0, $urandom_range(0, 24) != 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);

    idle(3 * WIN_LEN, 1'b1);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
